// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// Requester ids double as bit positions in the arbiter req/gnt vectors.
package rf_pkg;

    localparam int NREG = 16;
    localparam int AW   = 4;
    localparam int DW   = 16;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_id_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Issue, producer and register-file write signals of the write-back arbiter.
// The slave modport is the arbiter's view; master is the surrounding pipeline.
interface rf_wb_arbiter_if;
    import rf_pkg::*;

    logic            iss_valid;
    logic            iss_wr;
    logic [AW-1:0]   iss_rs1;
    logic [AW-1:0]   iss_rs2;
    logic [AW-1:0]   iss_rd;
    logic            iss_stall;

    logic            a_valid;
    logic [AW-1:0]   a_rd;
    logic [DW-1:0]   a_data;
    logic            a_ready;

    logic            b_valid;
    logic [AW-1:0]   b_rd;
    logic [DW-1:0]   b_data;
    logic            b_ready;

    logic            rf_wr;
    logic [AW-1:0]   rf_rd;
    logic [DW-1:0]   rf_wdata;
    logic [NREG-1:0] busy;

    modport slave (
        input  iss_valid, iss_wr, iss_rs1, iss_rs2, iss_rd,
        output iss_stall,
        input  a_valid, a_rd, a_data,
        output a_ready,
        input  b_valid, b_rd, b_data,
        output b_ready,
        output rf_wr, rf_rd, rf_wdata, busy
    );

    modport master (
        output iss_valid, iss_wr, iss_rs1, iss_rs2, iss_rd,
        input  iss_stall,
        output a_valid, a_rd, a_data,
        input  a_ready,
        output b_valid, b_rd, b_data,
        input  b_ready,
        input  rf_wr, rf_rd, rf_wdata, busy
    );

endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: under contention the requester not granted
// most recently wins; last grant only moves when a grant is actually taken.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_adv,
    output logic [1:0] o_gnt
);

    gnt_id_e r_last_grant;
    logic    w_both;

    assign w_both = i_req[GNT_A] & i_req[GNT_B];

    always_comb begin
        o_gnt = 2'b00;
        if (w_both) begin
            if (r_last_grant == GNT_B) o_gnt[GNT_A] = 1'b1;
            else                       o_gnt[GNT_B] = 1'b1;
        end else begin
            o_gnt = i_req;
        end
    end

    // Reset to B so A takes the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GNT_B;
        end else if (i_adv) begin
            r_last_grant <= o_gnt[GNT_B] ? GNT_B : GNT_A;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file: ALU and load/mul share one
// registered write port; a busy scoreboard stalls issue on RAW/WAW.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NREG = rf_pkg::NREG,
    parameter int AW   = rf_pkg::AW,
    parameter int DW   = rf_pkg::DW
) (
    input  logic              clk,
    input  logic              rst,
    rf_wb_arbiter_if.slave    bus
);

    logic [1:0]      w_req;
    logic [1:0]      w_gnt;
    logic            w_xfer;
    logic            w_set;
    logic            w_stall;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;

    logic            r_wr;
    logic [AW-1:0]   r_rd;
    logic [DW-1:0]   r_wdata;
    logic [NREG-1:0] r_busy;

    assign w_req[GNT_A] = bus.a_valid;
    assign w_req[GNT_B] = bus.b_valid;
    assign w_xfer       = |w_gnt;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_req),
        .i_adv (w_xfer),
        .o_gnt (w_gnt)
    );

    assign bus.a_ready = w_gnt[GNT_A];
    assign bus.b_ready = w_gnt[GNT_B];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= 1'b0;
            r_rd    <= '0;
            r_wdata <= '0;
        end else begin
            r_wr <= w_xfer;
            if (w_xfer) begin
                r_rd    <= w_gnt[GNT_A] ? bus.a_rd   : bus.b_rd;
                r_wdata <= w_gnt[GNT_A] ? bus.a_data : bus.b_data;
            end
        end
    end

    // No bypass: a reader stays stalled through the rf_wr cycle itself.
    assign w_stall = bus.iss_valid & (r_busy[bus.iss_rs1] | r_busy[bus.iss_rs2] |
                                      (bus.iss_wr & r_busy[bus.iss_rd]));
    assign w_set   = bus.iss_valid & bus.iss_wr & ~w_stall;

    assign w_set_mask = NREG'(w_set) << bus.iss_rd;
    assign w_clr_mask = NREG'(r_wr)  << r_rd;

    // Set is applied after clear so a same-index collision leaves the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_busy <= '0;
        else     r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
    end

    assign bus.iss_stall = w_stall;
    assign bus.rf_wr     = r_wr;
    assign bus.rf_rd     = r_rd;
    assign bus.rf_wdata  = r_wdata;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: reset, RAW stall, contention order,
// same-edge set/clear and asynchronous mid-operation reset.
module tb_rf_wb_arbiter;
    import rf_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rf_wb_arbiter_if bus();

    rf_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iss_valid = 0; bus.iss_wr = 0;
        bus.iss_rs1 = 0; bus.iss_rs2 = 0; bus.iss_rd = 0;
        bus.a_valid = 0; bus.a_rd = 0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_rd = 0; bus.b_data = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        // Arbitration is live during reset but must not move state.
        bus.a_valid = 1; bus.a_rd = 4'd3; bus.a_data = 16'h1234;
        #1;
        checks++; if (bus.a_ready !== 1'b1) begin failures++; $display("FAIL rst_a_ready: got %b exp 1", bus.a_ready); end
        tick();
        checks++; if (bus.rf_wr !== 1'b0) begin failures++; $display("FAIL rst_no_write: got %b exp 0", bus.rf_wr); end
        bus.a_valid = 0;
        rst = 1'b0;
        tick();
        checks++; if (bus.busy !== 16'h0000) begin failures++; $display("FAIL rel_busy: got %h exp 0000", bus.busy); end
        checks++; if (bus.rf_wr !== 1'b0) begin failures++; $display("FAIL rel_rf_wr: got %b exp 0", bus.rf_wr); end
        checks++; if ({bus.a_ready, bus.b_ready} !== 2'b00) begin failures++; $display("FAIL rel_ready: got %b exp 00", {bus.a_ready, bus.b_ready}); end
        checks++; if ({bus.rf_rd, bus.rf_wdata} !== 20'h0) begin failures++; $display("FAIL rel_rf_regs: got %h exp 00000", {bus.rf_rd, bus.rf_wdata}); end
        bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_rs1 = 4'd3; bus.iss_rs2 = 4'd4; bus.iss_rd = 4'd5;
        #1;
        checks++; if (bus.iss_stall !== 1'b0) begin failures++; $display("FAIL first_issue_stall: got %b exp 0", bus.iss_stall); end
        tick();
        bus.iss_valid = 0; bus.iss_wr = 0;
        checks++; if (bus.busy !== 16'h0020) begin failures++; $display("FAIL first_issue_busy: got %h exp 0020", bus.busy); end
    endtask

    task automatic test_raw();
        bus.iss_valid = 1; bus.iss_wr = 0; bus.iss_rs1 = 4'd5; bus.iss_rs2 = 4'd0;
        #1;
        checks++; if (bus.iss_stall !== 1'b1) begin failures++; $display("FAIL raw_stall: got %b exp 1", bus.iss_stall); end
        bus.a_valid = 1; bus.a_rd = 4'd5; bus.a_data = 16'hBEEF;
        #1;
        checks++; if ({bus.a_ready, bus.b_ready} !== 2'b10) begin failures++; $display("FAIL raw_ready: got %b exp 10", {bus.a_ready, bus.b_ready}); end
        tick();
        bus.a_valid = 0;
        checks++; if ({bus.rf_wr, bus.rf_rd, bus.rf_wdata} !== {1'b1, 4'd5, 16'hBEEF}) begin failures++; $display("FAIL raw_write: got %b/%0d/%h exp 1/5/beef", bus.rf_wr, bus.rf_rd, bus.rf_wdata); end
        checks++; if (bus.iss_stall !== 1'b1) begin failures++; $display("FAIL raw_stall_wr_cycle: got %b exp 1", bus.iss_stall); end
        tick();
        checks++; if (bus.iss_stall !== 1'b0) begin failures++; $display("FAIL raw_stall_clear: got %b exp 0", bus.iss_stall); end
        checks++; if (bus.busy !== 16'h0000) begin failures++; $display("FAIL raw_busy_clear: got %h exp 0000", bus.busy); end
        checks++; if (bus.rf_wr !== 1'b0) begin failures++; $display("FAIL raw_wr_drop: got %b exp 0", bus.rf_wr); end
        bus.iss_valid = 0;
    endtask

    task automatic test_contention();
        logic [3:0] exp_rd;
        // Last grant is A after the RAW test; a lone B write (to a non-busy
        // register) flips it so contention starts with A.
        bus.b_valid = 1; bus.b_rd = 4'd0; bus.b_data = 16'h00B0;
        tick();
        bus.b_valid = 0;
        checks++; if ({bus.rf_wr, bus.rf_rd, bus.rf_wdata} !== {1'b1, 4'd0, 16'h00B0}) begin failures++; $display("FAIL nb_write: got %b/%0d/%h exp 1/0/00b0", bus.rf_wr, bus.rf_rd, bus.rf_wdata); end
        tick();
        checks++; if (bus.busy !== 16'h0000) begin failures++; $display("FAIL nb_busy: got %h exp 0000", bus.busy); end
        bus.a_valid = 1; bus.a_rd = 4'd1; bus.a_data = 16'hAAAA;
        bus.b_valid = 1; bus.b_rd = 4'd2; bus.b_data = 16'hBBBB;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if ({bus.a_ready, bus.b_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL cont_grant%0d: got %b exp %b", k, {bus.a_ready, bus.b_ready}, (k % 2 == 0) ? 2'b10 : 2'b01); end
            tick();
            exp_rd = (k % 2 == 0) ? 4'd1 : 4'd2;
            checks++; if ({bus.rf_wr, bus.rf_rd} !== {1'b1, exp_rd}) begin failures++; $display("FAIL cont_rd%0d: got %b/%0d exp 1/%0d", k, bus.rf_wr, bus.rf_rd, exp_rd); end
            checks++; if (bus.rf_wdata !== ((k % 2 == 0) ? 16'hAAAA : 16'hBBBB)) begin failures++; $display("FAIL cont_data%0d: got %h", k, bus.rf_wdata); end
        end
        bus.a_valid = 0; bus.b_valid = 0;
        tick();
        checks++; if (bus.rf_wr !== 1'b0) begin failures++; $display("FAIL cont_idle: got %b exp 0", bus.rf_wr); end
    endtask

    task automatic test_same_edge();
        bus.iss_valid = 1; bus.iss_wr = 1; bus.iss_rs1 = 4'd0; bus.iss_rs2 = 4'd0; bus.iss_rd = 4'd7;
        tick();
        checks++; if (bus.busy !== 16'h0080) begin failures++; $display("FAIL se_busy_set: got %h exp 0080", bus.busy); end
        checks++; if (bus.iss_stall !== 1'b1) begin failures++; $display("FAIL se_waw_stall: got %b exp 1", bus.iss_stall); end
        bus.a_valid = 1; bus.a_rd = 4'd7; bus.a_data = 16'h7001;
        tick();
        bus.a_data = 16'h7002;
        checks++; if ({bus.rf_wr, bus.rf_rd} !== {1'b1, 4'd7}) begin failures++; $display("FAIL se_wr1: got %b/%0d exp 1/7", bus.rf_wr, bus.rf_rd); end
        checks++; if (bus.iss_stall !== 1'b1) begin failures++; $display("FAIL se_stall_wr_cycle: got %b exp 1", bus.iss_stall); end
        tick();
        bus.a_valid = 0;
        checks++; if (bus.iss_stall !== 1'b0) begin failures++; $display("FAIL se_stall_drop: got %b exp 0", bus.iss_stall); end
        checks++; if ({bus.rf_wr, bus.rf_rd, bus.rf_wdata} !== {1'b1, 4'd7, 16'h7002}) begin failures++; $display("FAIL se_wr2: got %b/%0d/%h exp 1/7/7002", bus.rf_wr, bus.rf_rd, bus.rf_wdata); end
        tick();
        bus.iss_valid = 0; bus.iss_wr = 0;
        checks++; if (bus.busy !== 16'h0080) begin failures++; $display("FAIL se_set_wins: got %h exp 0080", bus.busy); end
    endtask

    task automatic test_mid_reset();
        bus.iss_valid = 1; bus.iss_wr = 1;
        bus.iss_rd = 4'd4; tick();
        bus.iss_rd = 4'd5; tick();
        bus.iss_rd = 4'd6;
        bus.a_valid = 1; bus.a_rd = 4'd9; bus.a_data = 16'h0909;
        tick();
        bus.iss_valid = 0; bus.iss_wr = 0; bus.a_valid = 0;
        bus.b_valid = 1; bus.b_rd = 4'd10; bus.b_data = 16'h0A0A;
        checks++; if (bus.busy !== 16'h00F0) begin failures++; $display("FAIL mr_busy_pre: got %h exp 00f0", bus.busy); end
        checks++; if (bus.rf_wr !== 1'b1) begin failures++; $display("FAIL mr_wr_pre: got %b exp 1", bus.rf_wr); end
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.busy !== 16'h0000) begin failures++; $display("FAIL mr_busy_async: got %h exp 0000", bus.busy); end
        checks++; if (bus.rf_wr !== 1'b0) begin failures++; $display("FAIL mr_wr_async: got %b exp 0", bus.rf_wr); end
        checks++; if (bus.b_ready !== 1'b1) begin failures++; $display("FAIL mr_b_ready: got %b exp 1", bus.b_ready); end
        tick();
        checks++; if ({bus.rf_wr, bus.busy} !== 17'h0) begin failures++; $display("FAIL mr_hold: got %b/%h exp 0/0000", bus.rf_wr, bus.busy); end
        rst = 1'b0;
        bus.a_valid = 1; bus.a_rd = 4'd11; bus.a_data = 16'h0B0B;
        #1;
        checks++; if ({bus.a_ready, bus.b_ready} !== 2'b10) begin failures++; $display("FAIL mr_first_grant: got %b exp 10", {bus.a_ready, bus.b_ready}); end
        tick();
        bus.a_valid = 0; bus.b_valid = 0;
        checks++; if ({bus.rf_wr, bus.rf_rd, bus.rf_wdata} !== {1'b1, 4'd11, 16'h0B0B}) begin failures++; $display("FAIL mr_first_write: got %b/%0d/%h exp 1/11/0b0b", bus.rf_wr, bus.rf_rd, bus.rf_wdata); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_raw();
        test_contention();
        test_same_edge();
        test_mid_reset();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
